axi_mem_slave: RTL and testbench

AXI4 slave (responder) that terminates the core's memory-side AXI bus and serves read and write bursts from a single-port synchronous SRAM. It sits on the far side of the interconnect from the instruction-fetch and load/store masters. It holds one transaction in flight at a time, echoes transaction IDs, and reports OKAY or SLVERR per transaction.

---
 rtl/axi_mem_slave_if.sv | 64 ++++++
 rtl/axi_mem_slave.sv | 201 ++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between a memory-side master and axi_mem_slave.
interface axi_mem_slave_if #(
  parameter int unsigned ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [63:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [63:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: one burst in flight at a time, served from a single-port
// synchronous 64-bit SRAM, with ID echo and OKAY/SLVERR per transaction.
module axi_mem_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned MEM_AW    = 16,
  parameter int unsigned ID_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_mem_slave_if.slave    bus,
  output logic              mem_en,
  output logic [7:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);
  localparam logic [2:0]  IDLE     = 3'd0;
  localparam logic [2:0]  WR_DATA  = 3'd1;
  localparam logic [2:0]  WR_RESP  = 3'd2;
  localparam logic [2:0]  RD_ISSUE = 3'd3;
  localparam logic [2:0]  RD_DATA  = 3'd4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_RSVD  = 2'b11;
  localparam logic [64:0] SPAN = 65'(1) << (MEM_AW + 3);

  logic [2:0]        state, nxt;
  logic              rdy_q, rdy_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_first_q, rd_first_d;
  logic [63:0]       rdata_q;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              last_wr_q, last_wr_d;

  logic              sel_wr;
  logic [63:0]       cap_addr, cap_off;
  logic [2:0]        cap_size;
  logic [1:0]        cap_burst;
  logic              cap_err;
  logic              w_hs, w_last_beat, w_bad;
  logic [MEM_AW-1:0] addr_step;

  // Channel grant, address decode and per-beat helpers.
  always_comb begin
    sel_wr      = bus.awvalid && (!bus.arvalid || !last_wr_q);
    cap_addr    = sel_wr ? bus.awaddr  : bus.araddr;
    cap_size    = sel_wr ? bus.awsize  : bus.arsize;
    cap_burst   = sel_wr ? bus.awburst : bus.arburst;
    cap_off     = cap_addr - BASE_ADDR;
    cap_err     = (cap_size != 3'd3) || (cap_burst == BURST_RSVD) ||
                  (cap_addr < BASE_ADDR) || ({1'b0, cap_off} >= SPAN);
    w_hs        = (state == WR_DATA) && wready_q && bus.wvalid;
    w_last_beat = (cnt_q == len_q);
    w_bad       = (bus.wlast != w_last_beat);
    addr_step   = (burst_q == BURST_FIXED) ? addr_q : addr_q + MEM_AW'(1);
  end

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    nxt       = state;
    id_d      = id_q;
    len_d     = len_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    last_wr_d = last_wr_q;

    case (state)
      IDLE: begin
        if (rdy_q && (bus.awvalid || bus.arvalid)) begin
          nxt       = sel_wr ? WR_DATA : RD_ISSUE;
          id_d      = sel_wr ? bus.awid  : bus.arid;
          len_d     = sel_wr ? bus.awlen : bus.arlen;
          burst_d   = cap_burst;
          addr_d    = cap_off[MEM_AW+2:3];
          cnt_d     = 8'd0;
          err_d     = cap_err;
          last_wr_d = sel_wr;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          err_d  = err_q || w_bad;
          addr_d = addr_step;
          cnt_d  = cnt_q + 8'd1;
          if (w_last_beat) nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.bready) nxt = IDLE;
      end
      RD_ISSUE: nxt = RD_DATA;
      RD_DATA: begin
        if (bus.rready) begin
          if (rlast_q) begin
            nxt = IDLE;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_step;
            nxt    = RD_ISSUE;
          end
        end
      end
      default: nxt = IDLE;
    endcase

    rdy_d      = (nxt == IDLE);
    wready_d   = (nxt == WR_DATA);
    bvalid_d   = (nxt == WR_RESP);
    bid_d      = (nxt == WR_RESP) ? id_d : '0;
    bresp_d    = (nxt == WR_RESP && err_d) ? RESP_SLVERR : RESP_OKAY;
    rd_en_d    = (nxt == RD_ISSUE);
    rd_first_d = (state == RD_ISSUE);
    rvalid_d   = (nxt == RD_DATA);
    rid_d      = (nxt == RD_DATA) ? id_d : '0;
    rresp_d    = (nxt == RD_DATA && err_d) ? RESP_SLVERR : RESP_OKAY;
    rlast_d    = (nxt == RD_DATA) && (cnt_d == len_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= 64'h0;
      id_q       <= '0;
      len_q      <= 8'd0;
      burst_q    <= BURST_FIXED;
      addr_q     <= '0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      last_wr_q  <= 1'b0;
    end else begin
      state      <= nxt;
      rdy_q      <= rdy_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      rd_en_q    <= rd_en_d;
      rd_first_q <= rd_first_d;
      if (rd_first_q) rdata_q <= mem_rdata;
      id_q       <= id_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      last_wr_q  <= last_wr_d;
    end
  end

  assign bus.awready = rdy_q;
  assign bus.arready = rdy_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = rid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;

  // SRAM data arrives in the first RD_DATA cycle; it is bypassed then and held
  // afterwards so the beat stays stable however long rready is low.
  assign bus.rdata = (state == RD_DATA && !err_q) ?
                     (rd_first_q ? mem_rdata : rdata_q) : 64'h0;

  assign mem_en    = rd_en_q || w_hs;
  assign mem_we    = (w_hs && !err_q) ? bus.wstrb : 8'h00;
  assign mem_addr  = addr_q;
  assign mem_wdata = (state == WR_DATA) ? bus.wdata : 64'h0;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised self-checking bench for axi_mem_slave against a transaction-level
// memory model; the SRAM itself is a behavioural array in the bench.
module tb_axi_mem_slave;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          DEPTH = 65536;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  axi_mem_slave_if #(.ID_W(4)) bus ();

  axi_mem_slave #(.BASE_ADDR(BASE), .MEM_AW(16), .ID_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [63:0] sram [0:DEPTH-1];
  int          wr_strobes = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 8; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= sram[mem_addr];
    end
    if (mem_en && mem_we != 8'h00) wr_strobes <= wr_strobes + 1;
  end

  int          checks = 0;
  int          errors = 0;
  logic [63:0] ref_mem [int];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 64'h0;
  endfunction

  function automatic bit model_err(input logic [63:0] a, input logic [2:0] sz, input logic [1:0] bt);
    return (sz != 3'd3) || (bt == 2'b11) || (a < BASE) || ((a - BASE) >= 64'(8 * DEPTH));
  endfunction

  function automatic int word_of(input logic [63:0] a);
    logic [63:0] o;
    o = (a - BASE) / 64'd8;
    return int'(o % 64'(DEPTH));
  endfunction

  task automatic wait_ready(input bit is_aw);
    int cyc = 0;
    while (!(is_aw ? bus.awready : bus.arready)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 100) begin
        check(is_aw ? "aw_ready_timeout" : "ar_ready_timeout",
              64'(is_aw ? bus.awready : bus.arready), 64'd1);
        $fatal(1, "handshake timeout");
      end
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int bad_beat, input bit gaps);
    bit          err;
    int          w;
    logic [63:0] m;
    err = model_err(addr, size, burst);
    w   = word_of(addr);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len;
    bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    wait_ready(1'b1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.wvalid = 1'b0;
        #1;
        check("w_gap_en", 64'(mem_en), 64'd0);
        @(negedge clk);
      end
      bus.wdata = wd[i]; bus.wstrb = ws[i];
      bus.wlast = (i == int'(len)) != (i == bad_beat);
      bus.wvalid = 1'b1;
      #1;
      check("w_ready", 64'(bus.wready), 64'd1);
      check("w_en", 64'(mem_en), 64'd1);
      check("w_we", 64'(mem_we), 64'(err ? 8'h00 : ws[i]));
      if (!err) check("w_addr", 64'(mem_addr), 64'(w));
      check("w_wdata", mem_wdata, wd[i]);
      if (!err) begin
        m = ref_rd(w);
        for (int b = 0; b < 8; b++) if (ws[i][b]) m[8*b +: 8] = wd[i][8*b +: 8];
        ref_mem[w] = m;
      end
      if (bus.wlast != (i == int'(len))) err = 1'b1;
      if (burst != 2'b00) w = (w + 1) % DEPTH;
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("b_valid_timing", 64'(bus.bvalid), 64'd1);
    repeat ($urandom_range(0, 2)) begin
      check("b_hold_valid", 64'(bus.bvalid), 64'd1);
      check("b_hold_id", 64'(bus.bid), 64'(id));
      @(negedge clk);
    end
    bus.bready = 1'b1;
    check("b_id", 64'(bus.bid), 64'(id));
    check("b_resp", 64'(bus.bresp), err ? 64'd2 : 64'd0);
    @(negedge clk);
    bus.bready = 1'b0;
    check("b_done_idle", 64'(bus.awready), 64'd1);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
    bit          err, tog, rr, hs;
    int          w, k;
    logic [63:0] exp;
    err = model_err(addr, size, burst);
    w   = word_of(addr);
    tog = 1'b0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len;
    bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    wait_ready(1'b0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      check("rd_issue_en", 64'(mem_en), 64'd1);
      check("rd_issue_we", 64'(mem_we), 64'd0);
      check("rd_issue_rvalid", 64'(bus.rvalid), 64'd0);
      if (!err) check("rd_issue_addr", 64'(mem_addr), 64'(w));
      @(negedge clk);
      exp = err ? 64'h0 : ref_rd(w);
      hs = 1'b0;
      k  = 0;
      while (!hs) begin
        case (mode)
          0:       rr = 1'b1;
          1:       begin rr = tog; tog = !tog; end
          default: rr = (k >= 5) ? 1'b1 : 1'(($urandom_range(0, 1)));
        endcase
        bus.rready = rr;
        check("r_valid", 64'(bus.rvalid), 64'd1);
        check("r_data", bus.rdata, exp);
        check("r_resp", 64'(bus.rresp), err ? 64'd2 : 64'd0);
        check("r_last", 64'(bus.rlast), 64'(i == int'(len)));
        check("r_id", 64'(bus.rid), 64'(id));
        hs = rr;
        k++;
        @(negedge clk);
      end
      bus.rready = 1'b0;
      if (burst != 2'b00) w = (w + 1) % DEPTH;
    end
    check("r_done_idle", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    int          cnt0;
    logic [63:0] d;
    logic [63:0] a;
    int          word;

    for (int i = 0; i < DEPTH; i++) sram[i] = 64'h0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Arbitration: both address valids held from reset -> W, R, W, R.
    bus.awid = 4'd5; bus.awaddr = BASE + 64'd800; bus.awlen = 8'd0; bus.awsize = 3'd3;
    bus.awburst = 2'b01; bus.arid = 4'd6; bus.araddr = BASE + 64'd800; bus.arlen = 8'd0;
    bus.arsize = 3'd3; bus.arburst = 2'b01;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_ready(1'b1);
      @(negedge clk);
      if (t == 3) begin bus.awvalid = 1'b0; bus.arvalid = 1'b0; end
      check("arb_grant_wr", 64'(bus.wready), 64'(t % 2 == 0));
      if (t % 2 == 0) begin
        d = {$urandom, $urandom};
        bus.wdata = d; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        ref_mem[100] = d;
        @(negedge clk);
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        check("arb_bvalid", 64'(bus.bvalid), 64'd1);
        check("arb_bid", 64'(bus.bid), 64'd5);
        check("arb_bresp", 64'(bus.bresp), 64'd0);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
      end else begin
        check("arb_rd_en", 64'(mem_en), 64'd1);
        @(negedge clk);
        check("arb_rvalid", 64'(bus.rvalid), 64'd1);
        check("arb_rid", 64'(bus.rid), 64'd6);
        check("arb_rdata", bus.rdata, ref_rd(100));
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
      end
    end

    // Single write then read back, id 3 at word 2.
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    axi_write(4'd3, 64'h8000_0010, 8'd0, 3'd3, 2'b01, -1, 1'b0);
    axi_read(4'd3, 64'h8000_0010, 8'd0, 3'd3, 2'b01, 0);

    // INCR burst of four words, read back with rready toggling.
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(4'd1, BASE, 8'd3, 3'd3, 2'b01, -1, 1'b0);
    axi_read(4'd2, BASE, 8'd3, 3'd3, 2'b01, 1);

    // FIXED burst: two half-word strobes land on the same word.
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; ws[0] = 8'hFF;
    axi_write(4'd4, BASE + 64'd160, 8'd0, 3'd3, 2'b01, -1, 1'b0);
    wd[0] = 64'h0000_0000_1234_5678; ws[0] = 8'h0F;
    wd[1] = 64'h9ABC_DEF0_0000_0000; ws[1] = 8'hF0;
    axi_write(4'd4, BASE + 64'd160, 8'd1, 3'd3, 2'b00, -1, 1'b0);
    axi_read(4'd4, BASE + 64'd160, 8'd0, 3'd3, 2'b01, 2);
    check("fixed_merge", ref_rd(20), 64'h9ABC_DEF0_1234_5678);

    // Error cases.
    cnt0 = wr_strobes;
    axi_read(4'd7, 64'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 0);
    check("err_rd_nowrite", 64'(wr_strobes), 64'(cnt0));
    wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
    axi_write(4'd8, BASE + 64'd240, 8'd0, 3'd2, 2'b01, -1, 1'b0);
    check("err_size_nowrite", 64'(wr_strobes), 64'(cnt0));
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(4'd9, BASE + 64'd320, 8'd3, 3'd3, 2'b01, 1, 1'b0);
    axi_read(4'd9, BASE + 64'd320, 8'd3, 3'd3, 2'b01, 0);

    // Randomised mixed traffic, including wrap past the top word.
    for (int n = 0; n < 40; n++) begin
      word = ($urandom_range(0, 7) == 0) ? (DEPTH - 4 + int'($urandom_range(0, 3)))
                                         : int'($urandom_range(0, 31));
      a = BASE + 64'(word) * 64'd8;
      for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
      if ($urandom_range(0, 1) == 1)
        axi_write(4'($urandom), a, 8'($urandom_range(0, 5)),
                  ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3, 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1, 1'b1);
      else
        axi_read(4'($urandom), a, 8'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3, 2'($urandom_range(0, 2)), 2);
    end

    // Reset in the middle of a read burst.
    bus.arid = 4'd9; bus.araddr = BASE + 64'd40; bus.arlen = 8'd3;
    bus.arsize = 3'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    wait_ready(1'b0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("mid_rvalid", 64'(bus.rvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_awready0", 64'(bus.awready), 64'd0);
    check("rst_arready0", 64'(bus.arready), 64'd0);
    check("rst_wready0", 64'(bus.wready), 64'd0);
    check("rst_bvalid0", 64'(bus.bvalid), 64'd0);
    check("rst_bid0", 64'(bus.bid), 64'd0);
    check("rst_bresp0", 64'(bus.bresp), 64'd0);
    check("rst_rvalid0", 64'(bus.rvalid), 64'd0);
    check("rst_rid0", 64'(bus.rid), 64'd0);
    check("rst_rdata0", bus.rdata, 64'd0);
    check("rst_rresp0", 64'(bus.rresp), 64'd0);
    check("rst_rlast0", 64'(bus.rlast), 64'd0);
    check("rst_mem_en0", 64'(mem_en), 64'd0);
    check("rst_mem_we0", 64'(mem_we), 64'd0);
    check("rst_mem_addr0", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata0", mem_wdata, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", 64'(bus.awready), 64'd1);
    check("post_rst_arready", 64'(bus.arready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
